nec_ir_tx: RTL and testbench

NEC-format infrared transmitter, the sending end of the IR link our receiver path decodes. It accepts one address byte and one command byte through a valid/ready handshake. It then serialises a full NEC frame: leader, 32 data bits (addr, ~addr, cmd, ~cmd, each LSB first) and stop mark. The frame is driven onto the IR LED pin with timing derived from a 562.5 us base tick generated off CLOCK_50.

---
 rtl/nec_ir_pkg.sv | 35 +++
 rtl/ir_tick_gen.sv | 47 ++++
 rtl/nec_ir_tx.sv | 210 +++++++++++++++++++++
 tb/tb_nec_ir_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nec_ir_pkg.sv
// ---------------------------------------------------------------------------
// nec_ir_pkg
// Shared definitions for the NEC infrared transmitter: FSM state encoding,
// per-state durations in 562.5 us base ticks, and the helper that packs an
// address/command pair into the 32-bit on-air frame.
// No ports (package).
// ---------------------------------------------------------------------------
package nec_ir_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LEAD_MARK  = 3'd1,
    LEAD_SPACE = 3'd2,
    BIT_MARK   = 3'd3,
    BIT_SPACE  = 3'd4,
    STOP_MARK  = 3'd5,
    GAP        = 3'd6
  } state_t;

  localparam int LEAD_MARK_TICKS  = 16;
  localparam int LEAD_SPACE_TICKS = 8;
  localparam int BIT_MARK_TICKS   = 1;
  localparam int ZERO_SPACE_TICKS = 1;
  localparam int ONE_SPACE_TICKS  = 3;
  localparam int STOP_MARK_TICKS  = 1;
  localparam int FRAME_BITS       = 32;

  // Bit 0 of the result is the first bit on air (addr[0]); each byte is
  // followed by its complement so a receiver can validate the frame.
  function automatic logic [31:0] buildFrame(input logic [7:0] addr,
                                             input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// ---------------------------------------------------------------------------
// ir_tick_gen
// Divides the system clock down to the NEC base tick (562.5 us at 50 MHz).
// Ports:
//   i_clk       system clock
//   i_rst       asynchronous active-high reset
//   i_enable    counter advances only while high
//   i_clear     synchronous clear, wins over enable
//   o_tick      high on the last clock of each tick period
//   o_preTick   high one clock before o_tick, lets the parent register
//               outputs that must line up with the tick cycle itself
// ---------------------------------------------------------------------------
module ir_tick_gen #(
  parameter int TICK_CYCLES = 28125
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_tick,
  output logic o_preTick
);

  localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] r_count;

  // Free-running modulo-TICK_CYCLES counter; the clear lets a new frame
  // start its first tick period from a known phase.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      if (r_count == CW'(TICK_CYCLES - 1)) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign o_tick    = i_enable && (r_count == CW'(TICK_CYCLES - 1));
  assign o_preTick = i_enable && (r_count == CW'(TICK_CYCLES - 2));

endmodule

// File: rtl/nec_ir_tx.sv
// ---------------------------------------------------------------------------
// nec_ir_tx
// NEC-format infrared transmitter. Accepts an address/command pair through a
// valid/ready handshake and sends leader, 32 data bits (addr, ~addr, cmd,
// ~cmd, LSB first) and a stop mark, followed by an enforced idle gap.
// Ports:
//   CLOCK_50    system clock, 50 MHz
//   rst         asynchronous active-high reset
//   tx_valid    frame request, accepted when tx_ready_O is high
//   tx_addr     NEC address byte
//   tx_cmd      NEC command byte
//   tx_ready_O  high only while idle
//   busy_O      high from the cycle after accept until the gap completes
//   done_O      one-cycle pulse on the last cycle of the stop mark
//   mark_O      registered envelope, 1 = burst
//   IRDA_TXD    LED drive: envelope, or envelope gated by the carrier
// Build option: define IR_TX_CARRIER_EN to modulate IRDA_TXD with a 38 kHz
// carrier; without it IRDA_TXD carries the bare envelope.
// ---------------------------------------------------------------------------
module nec_ir_tx
  import nec_ir_pkg::*;
#(
  parameter int TICK_CYCLES  = 28125,
  parameter int GAP_TICKS    = 64,
  parameter int CARRIER_HALF = 658
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_addr,
  input  logic [7:0] tx_cmd,
  output logic       tx_ready_O,
  output logic       busy_O,
  output logic       done_O,
  output logic       mark_O,
  output logic       IRDA_TXD
);

  // Duration counter must also span the gap, which is longer than any
  // frame state.
  localparam int DUR_W = ($clog2(GAP_TICKS) > 5) ? $clog2(GAP_TICKS) : 5;

  state_t           r_state;
  logic [DUR_W-1:0] r_dur;
  logic [5:0]       r_idx;
  logic [31:0]      r_shift;
  logic             r_mark;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic w_accept;
  logic w_tick;
  logic w_preTick;
  logic w_lastTick;
  int   w_stateTicks;

  assign w_accept = (r_state == IDLE) && tx_valid;

  ir_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tickGen (
    .i_clk     (CLOCK_50),
    .i_rst     (rst),
    .i_enable  (r_busy),
    .i_clear   (w_accept),
    .o_tick    (w_tick),
    .o_preTick (w_preTick)
  );

  // Number of base ticks the current state lasts; a data bit's space length
  // encodes its value.
  always_comb begin
    w_stateTicks = 1;
    case (r_state)
      LEAD_MARK:  w_stateTicks = LEAD_MARK_TICKS;
      LEAD_SPACE: w_stateTicks = LEAD_SPACE_TICKS;
      BIT_MARK:   w_stateTicks = BIT_MARK_TICKS;
      BIT_SPACE:  w_stateTicks = r_shift[0] ? ONE_SPACE_TICKS : ZERO_SPACE_TICKS;
      STOP_MARK:  w_stateTicks = STOP_MARK_TICKS;
      GAP:        w_stateTicks = GAP_TICKS;
      default:    w_stateTicks = 1;
    endcase
  end

  assign w_lastTick = (r_dur == DUR_W'(w_stateTicks - 1));

  // Frame sequencer. Outputs are registered alongside the state so the
  // envelope changes exactly on the tick that ends each state. done_O is
  // armed one clock early (pre-tick) so that it lands on the final cycle of
  // the stop mark rather than the first cycle of the gap.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_dur   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_mark  <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == STOP_MARK) && w_preTick && w_lastTick;
      case (r_state)
        IDLE: begin
          r_dur <= '0;
          r_idx <= '0;
          if (tx_valid) begin
            r_shift <= buildFrame(tx_addr, tx_cmd);
            r_state <= LEAD_MARK;
            r_mark  <= 1'b1;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP: begin
          if (w_tick) begin
            if (!w_lastTick) begin
              r_dur <= r_dur + DUR_W'(1);
            end else begin
              r_dur <= '0;
              case (r_state)
                LEAD_MARK: begin
                  r_state <= LEAD_SPACE;
                  r_mark  <= 1'b0;
                end
                LEAD_SPACE: begin
                  r_state <= BIT_MARK;
                  r_mark  <= 1'b1;
                end
                BIT_MARK: begin
                  r_state <= BIT_SPACE;
                  r_mark  <= 1'b0;
                end
                BIT_SPACE: begin
                  r_shift <= r_shift >> 1;
                  r_idx   <= r_idx + 6'd1;
                  r_mark  <= 1'b1;
                  if (r_idx == 6'(FRAME_BITS - 1)) begin
                    r_state <= STOP_MARK;
                  end else begin
                    r_state <= BIT_MARK;
                  end
                end
                STOP_MARK: begin
                  r_state <= GAP;
                  r_mark  <= 1'b0;
                end
                default: begin
                  r_state <= IDLE;
                  r_mark  <= 1'b0;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                end
              endcase
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_dur   <= '0;
          r_idx   <= '0;
          r_mark  <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready_O = r_ready;
  assign busy_O     = r_busy;
  assign done_O     = r_done;
  assign mark_O     = r_mark;

`ifdef IR_TX_CARRIER_EN
  localparam int CCW = (CARRIER_HALF > 2) ? $clog2(CARRIER_HALF) : 1;

  logic [CCW-1:0] r_carrCnt;
  logic           r_phase;

  // Carrier half-period counter. Every burst is preceded by a space or idle
  // cycle, so holding the counter and phase in their start values while the
  // envelope is low guarantees each burst opens with a high half-cycle.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_carrCnt <= '0;
      r_phase   <= 1'b1;
    end else if (!r_mark) begin
      r_carrCnt <= '0;
      r_phase   <= 1'b1;
    end else if (r_carrCnt == CCW'(CARRIER_HALF - 1)) begin
      r_carrCnt <= '0;
      r_phase   <= ~r_phase;
    end else begin
      r_carrCnt <= r_carrCnt + CCW'(1);
    end
  end

  assign IRDA_TXD = r_mark & r_phase;
`else
  logic w_unusedCarrierCfg;

  // Envelope-only build: the carrier parameter stays referenced so the
  // interface is identical in both builds.
  assign w_unusedCarrierCfg = (CARRIER_HALF > 1);
  assign IRDA_TXD           = r_mark;
`endif

endmodule

// File: tb/tb_nec_ir_tx.sv
// ---------------------------------------------------------------------------
// tb_nec_ir_tx
// Directed self-checking bench for nec_ir_tx with shortened timing
// (4 clocks per tick, 4-tick gap, 3-clock carrier half period).
// ---------------------------------------------------------------------------
module tb_nec_ir_tx;

  localparam int T    = 4;
  localparam int GAPT = 4;
  localparam int CH   = 3;
  localparam int MAXC = 1200;
`ifdef IR_TX_CARRIER_EN
  localparam bit CARRIER_ON = 1'b1;
`else
  localparam bit CARRIER_ON = 1'b0;
`endif

  logic       CLOCK_50;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_addr;
  logic [7:0] tx_cmd;
  logic       tx_ready_O;
  logic       busy_O;
  logic       done_O;
  logic       mark_O;
  logic       IRDA_TXD;

  int errCount   = 0;
  int checkCount = 0;

  logic capMark  [0:MAXC];
  logic capDone  [0:MAXC];
  logic capReady [0:MAXC];
  logic capBusy  [0:MAXC];
  logic capTxd   [0:MAXC];
  logic expMark  [0:MAXC];

  nec_ir_tx #(
    .TICK_CYCLES  (T),
    .GAP_TICKS    (GAPT),
    .CARRIER_HALF (CH)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_addr    (tx_addr),
    .tx_cmd     (tx_cmd),
    .tx_ready_O (tx_ready_O),
    .busy_O     (busy_O),
    .done_O     (done_O),
    .mark_O     (mark_O),
    .IRDA_TXD   (IRDA_TXD)
  );

  // 10 ns clock period.
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Starts a request and records outputs for n cycles; cycle 1 is the first
  // cycle after the accepting edge. Inputs are altered after sampling.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] c,
                               input int dropAt, input int changeAt,
                               input logic [7:0] a2, input logic [7:0] c2,
                               input int n);
    tx_addr  = a;
    tx_cmd   = c;
    tx_valid = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(posedge CLOCK_50);
      #1;
      capMark[i]  = mark_O;
      capDone[i]  = done_O;
      capReady[i] = tx_ready_O;
      capBusy[i]  = busy_O;
      capTxd[i]   = IRDA_TXD;
      if (i == dropAt) tx_valid = 1'b0;
      if (i == changeAt) begin
        tx_addr = a2;
        tx_cmd  = c2;
      end
    end
  endtask

  task automatic clearExpected();
    for (int i = 0; i <= MAXC; i++) expMark[i] = 1'b0;
  endtask

  task automatic addSeg(inout int pos, input int ticks, input logic lvl);
    for (int k = 0; k < ticks * T; k++) begin
      if (pos <= MAXC) expMark[pos] = lvl;
      pos++;
    end
  endtask

  // Reference NEC envelope built straight from the protocol definition.
  task automatic buildExpected(input logic [7:0] a, input logic [7:0] c,
                               inout int pos);
    logic [31:0] d;
    d = {~c, c, ~a, a};
    addSeg(pos, 16, 1'b1);
    addSeg(pos, 8, 1'b0);
    for (int b = 0; b < 32; b++) begin
      addSeg(pos, 1, 1'b1);
      addSeg(pos, d[b] ? 3 : 1, 1'b0);
    end
    addSeg(pos, 1, 1'b1);
    addSeg(pos, GAPT, 1'b0);
  endtask

  function automatic int markMismatches(input int n);
    int cnt = 0;
    for (int i = 1; i <= n; i++) if (capMark[i] !== expMark[i]) cnt++;
    return cnt;
  endfunction

  // Expected LED drive: envelope, gated by a carrier whose phase restarts
  // high at the start of every burst when the carrier is built in.
  function automatic int txdMismatches(input int n);
    int  cnt = 0;
    int  off = 0;
    logic e;
    for (int i = 1; i <= n; i++) begin
      if (expMark[i] && !expMark[i-1]) off = 0;
      e = expMark[i] && (!CARRIER_ON || (((off / CH) % 2) == 0));
      if (capTxd[i] !== e) cnt++;
      if (expMark[i]) off++;
    end
    return cnt;
  endfunction

  function automatic int countRun(input int start, input logic lvl);
    int r = 0;
    while ((start + r) <= MAXC && capMark[start + r] === lvl) r++;
    return r;
  endfunction

  function automatic int firstDone(input int n);
    for (int i = 1; i <= n; i++) if (capDone[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int doneCount(input int n);
    int cnt = 0;
    for (int i = 1; i <= n; i++) if (capDone[i] === 1'b1) cnt++;
    return cnt;
  endfunction

  // Directed test sequence.
  initial begin
    int pos;
    int act;

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_addr  = 8'h00;
    tx_cmd   = 8'h00;
    for (int i = 0; i <= MAXC; i++) begin
      capMark[i] = 1'b0; capDone[i] = 1'b0; capReady[i] = 1'b0;
      capBusy[i] = 1'b0; capTxd[i] = 1'b0;
    end
    repeat (3) @(posedge CLOCK_50);
    #1;
    checkOutput("rstReady", tx_ready_O, 1);
    checkOutput("rstBusy",  busy_O, 0);
    checkOutput("rstMark",  mark_O, 0);
    checkOutput("rstDone",  done_O, 0);
    checkOutput("rstTxd",   IRDA_TXD, 0);
    rst = 1'b0;

    $display("[TB] idle with tx_valid low");
    act = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge CLOCK_50);
      #1;
      if (mark_O || busy_O || done_O || IRDA_TXD || !tx_ready_O) act++;
    end
    checkOutput("idleActivity", act, 0);
    checkOutput("idleBusy", busy_O, 0);
    checkOutput("idleMark", mark_O, 0);

    $display("[TB] single frame addr=00 cmd=45");
    applyStimulus(8'h00, 8'h45, 1, 0, 8'h00, 8'h00, 520);
    clearExpected();
    pos = 1;
    buildExpected(8'h00, 8'h45, pos);
    checkOutput("acceptReady", capReady[1], 0);
    checkOutput("acceptBusy",  capBusy[1], 1);
    checkOutput("leadMark",    countRun(1, 1'b1), 64);
    checkOutput("leadSpace",   countRun(65, 1'b0), 32);
    checkOutput("bit0Mark",    countRun(97, 1'b1), 4);
    checkOutput("bit0Space",   countRun(101, 1'b0), 4);
    checkOutput("bit8Mark",    countRun(161, 1'b1), 4);
    checkOutput("bit8Space",   countRun(165, 1'b0), 12);
    checkOutput("doneCycle",   firstDone(520), 484);
    checkOutput("doneCount",   doneCount(520), 1);
    checkOutput("readyLow500", capReady[500], 0);
    checkOutput("busyHigh500", capBusy[500], 1);
    checkOutput("readyBack",   capReady[501], 1);
    checkOutput("busyLow501",  capBusy[501], 0);
    checkOutput("frameWave",   markMismatches(520), 0);
    checkOutput("frameTxd",    txdMismatches(520), 0);

    $display("[TB] back-to-back frames with tx_valid held");
    applyStimulus(8'h12, 8'h34, 600, 100, 8'h56, 8'h78, 1050);
    clearExpected();
    pos = 1;
    buildExpected(8'h12, 8'h34, pos);
    pos++;
    buildExpected(8'h56, 8'h78, pos);
    checkOutput("b2bGapSpace",   countRun(485, 1'b0), GAPT * T + 1);
    checkOutput("b2bReadyIdle",  capReady[501], 1);
    checkOutput("b2bReadyTaken", capReady[502], 0);
    checkOutput("b2bSecondLead", countRun(502, 1'b1), 64);
    checkOutput("b2bDoneCount",  doneCount(1050), 2);
    checkOutput("b2bWave",       markMismatches(1050), 0);
    checkOutput("b2bTxd",        txdMismatches(1050), 0);

    $display("[TB] reset in the middle of a frame");
    applyStimulus(8'h00, 8'h45, 1, 0, 8'h00, 8'h00, 200);
    checkOutput("preRstSpace", capMark[200], 0);
    checkOutput("preRstBusy",  capBusy[200], 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRstTxd",   IRDA_TXD, 0);
    checkOutput("midRstReady", tx_ready_O, 1);
    checkOutput("midRstBusy",  busy_O, 0);
    checkOutput("midRstMark",  mark_O, 0);
    @(posedge CLOCK_50);
    #1;
    rst = 1'b0;
    applyStimulus(8'hA5, 8'h3C, 1, 0, 8'h00, 8'h00, 520);
    clearExpected();
    pos = 1;
    buildExpected(8'hA5, 8'h3C, pos);
    checkOutput("postRstLead", countRun(1, 1'b1), 64);
    checkOutput("postRstDone", firstDone(520), 484);
    checkOutput("postRstWave", markMismatches(520), 0);
    checkOutput("postRstTxd",  txdMismatches(520), 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
